wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
Two-master to one-slave Wishbone classic arbiter in front of the sentinel core's memory/IO bus. Master 0 is the core and master 1 is a secondary requester such as a debug or DMA engine. Grants are round-robin, one whole cycle (cyc high to cyc low) at a time. A wait-state watchdog aborts slave accesses that hog the bus, so forward progress is guaranteed.

Parameters:
ADDR_W, 30, word address width
DATA_W, 32, data width
SEL_W, 4, byte-select width (DATA_W/8)
TIMEOUT, 7, max wait cycles (stb high, ack low) before abort; legal range 1..255

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
m0__cyc, m0__stb, m0__we  in  1 each  master 0 control
m0__adr  in  ADDR_W  master 0 address
m0__sel  in  SEL_W  master 0 byte selects
m0__dat_w  in  DATA_W  master 0 write data
m0__dat_r  out  DATA_W  master 0 read data
m0__ack  out  1  master 0 acknowledge
m1__*  same set as m0__*  master 1
s__cyc, s__stb, s__we  out  1 each  slave control
s__adr  out  ADDR_W  slave address
s__sel  out  SEL_W  slave byte selects
s__dat_w  out  DATA_W  slave write data
s__dat_r  in  DATA_W  slave read data
s__ack  in  1  slave acknowledge
grant  out  1  index of the owning master; valid in BUSY/ABORT
busy  out  1  high in BUSY or ABORT
timeout  out  1  one-cycle pulse during ABORT

Behaviour:
- Reset (async, immediate): state=IDLE, last=1, wait counter=0, grant=0. All s__* and m*__ack/dat_r outputs are 0, busy=0, timeout=0.
- States: IDLE, BUSY, ABORT. grant, last and the counter are registered; all bus outputs are combinational from state, grant and inputs.
- IDLE:
  - Slave outputs are 0 and m*__ack is 0.
  - If exactly one mN__cyc is high: grant<=N, go to BUSY.
  - If both are high: grant<=~last (m0 wins the first contention after reset), go to BUSY.
  - Latency is 1 cycle from request to s__cyc.
- BUSY:
  - s__cyc = m[grant]__cyc; s__stb, s__we, s__adr, s__sel and s__dat_w pass through from the granted master.
  - m[grant]__ack = s__ack and m[grant]__dat_r = s__dat_r. The non-granted master sees ack=0 and dat_r=0.
  - When m[grant]__cyc is low: last<=grant, go to IDLE. Exactly one idle cycle separates grants, which forces a re-arbitration.
- Watchdog:
  - The counter increments in BUSY while s__stb && !s__ack and clears on s__ack or when leaving BUSY.
  - When the counter == TIMEOUT with stb high and ack low, go to ABORT on the next edge.
  - The counter is $clog2(TIMEOUT+1) bits wide and never wraps.
- ABORT (1 cycle):
  - s__cyc = s__stb = 0.
  - m[grant]__ack = 1, m[grant]__dat_r = all ones, timeout = 1.
  - Next state is BUSY if m[grant]__cyc is still high (counter cleared); otherwise IDLE with last<=grant.
- s__ack outside BUSY is ignored: stale acks never reach a master.
- If s__ack arrives on the same cycle the counter hits TIMEOUT, the ack wins: the transfer completes normally and there is no ABORT.
- A master dropping cyc mid-wait (stb high, no ack) ends the grant; the slave sees cyc fall the same cycle.
- A requesting master with no grant simply waits. No ack is ever generated for it, and there is no starvation beyond one foreign bus cycle.
- rst mid-BUSY: all outputs drop within the same cycle (async), and arbitration restarts with m0 priority.

Test Plan:
- m0 read only, adr=0x100, slave acks 2 cycles after s__stb with dat_r=0xDEADBEEF -> grant=0; s__cyc rises 1 cycle after m0__cyc; m0__ack is a single pulse with 0xDEADBEEF; m1__ack stays 0.
- m0 and m1 raise cyc together after reset -> m0 served first; after m0 drops cyc, 1 IDLE cycle, then grant=1 with m1's adr/sel/we/dat_w visible on s__*.
- m0 issues back-to-back cycles while m1 holds cyc -> grants alternate 0,1,0; m1 never waits more than one m0 cycle.
- TIMEOUT=7, slave never acks m1 read -> ABORT 8 cycles after s__stb; m1__ack=1, m1__dat_r=0xFFFFFFFF and timeout=1 for exactly one cycle; s__cyc=0 in that cycle.
- s__ack asserted exactly on the counter==TIMEOUT cycle -> normal ack with slave data, timeout stays 0.
- rst asserted mid-BUSY between edges -> s__cyc, m*__ack and busy go 0 immediately; after release, simultaneous requests grant m0.

Source files
------------

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone classic arbiter with round-robin grants
// and a wait-state watchdog that aborts slave accesses which never ack.
module wb_arbiter2 #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0__cyc,
    input  logic              m0__stb,
    input  logic              m0__we,
    input  logic [ADDR_W-1:0] m0__adr,
    input  logic [SEL_W-1:0]  m0__sel,
    input  logic [DATA_W-1:0] m0__dat_w,
    output logic [DATA_W-1:0] m0__dat_r,
    output logic              m0__ack,
    input  logic              m1__cyc,
    input  logic              m1__stb,
    input  logic              m1__we,
    input  logic [ADDR_W-1:0] m1__adr,
    input  logic [SEL_W-1:0]  m1__sel,
    input  logic [DATA_W-1:0] m1__dat_w,
    output logic [DATA_W-1:0] m1__dat_r,
    output logic              m1__ack,
    output logic              s__cyc,
    output logic              s__stb,
    output logic              s__we,
    output logic [ADDR_W-1:0] s__adr,
    output logic [SEL_W-1:0]  s__sel,
    output logic [DATA_W-1:0] s__dat_w,
    input  logic [DATA_W-1:0] s__dat_r,
    input  logic              s__ack,
    output logic              grant,
    output logic              busy,
    output logic              timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    state_t             state, state_n;
    logic               grant_n;
    logic               last, last_n;
    logic [CNT_W-1:0]   cnt, cnt_n;

    logic               g_cyc, g_stb, g_we;
    logic [ADDR_W-1:0]  g_adr;
    logic [SEL_W-1:0]   g_sel;
    logic [DATA_W-1:0]  g_dat_w;

    assign g_cyc   = grant ? m1__cyc   : m0__cyc;
    assign g_stb   = grant ? m1__stb   : m0__stb;
    assign g_we    = grant ? m1__we    : m0__we;
    assign g_adr   = grant ? m1__adr   : m0__adr;
    assign g_sel   = grant ? m1__sel   : m0__sel;
    assign g_dat_w = grant ? m1__dat_w : m0__dat_w;

    assign busy = (state != IDLE);

    // last starts at 1 so the first contention after reset goes to m0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            last  <= last_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        last_n    = last;
        cnt_n     = cnt;
        s__cyc    = 1'b0;
        s__stb    = 1'b0;
        s__we     = 1'b0;
        s__adr    = '0;
        s__sel    = '0;
        s__dat_w  = '0;
        m0__ack   = 1'b0;
        m1__ack   = 1'b0;
        m0__dat_r = '0;
        m1__dat_r = '0;
        timeout   = 1'b0;

        case (state)
            IDLE: begin
                if (m0__cyc && m1__cyc) begin
                    grant_n = ~last;
                    state_n = BUSY;
                end else if (m0__cyc) begin
                    grant_n = 1'b0;
                    state_n = BUSY;
                end else if (m1__cyc) begin
                    grant_n = 1'b1;
                    state_n = BUSY;
                end
            end

            BUSY: begin
                s__cyc   = g_cyc;
                s__stb   = g_stb;
                s__we    = g_we;
                s__adr   = g_adr;
                s__sel   = g_sel;
                s__dat_w = g_dat_w;
                if (grant) begin
                    m1__ack   = s__ack;
                    m1__dat_r = s__dat_r;
                end else begin
                    m0__ack   = s__ack;
                    m0__dat_r = s__dat_r;
                end

                // An ack on the TIMEOUT cycle completes normally, so it is tested first
                if (!g_cyc) begin
                    state_n = IDLE;
                    last_n  = grant;
                    cnt_n   = '0;
                end else if (s__ack) begin
                    cnt_n = '0;
                end else if (g_stb && cnt == CNT_W'(TIMEOUT)) begin
                    state_n = ABORT;
                    cnt_n   = '0;
                end else if (g_stb) begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            ABORT: begin
                timeout = 1'b1;
                if (grant) begin
                    m1__ack   = 1'b1;
                    m1__dat_r = '1;
                end else begin
                    m0__ack   = 1'b1;
                    m0__dat_r = '1;
                end
                cnt_n = '0;
                if (g_cyc) begin
                    state_n = BUSY;
                end else begin
                    state_n = IDLE;
                    last_n  = grant;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed self-checking bench for wb_arbiter2: arbitration order, pass-through,
// watchdog abort, ack-wins-at-timeout and asynchronous reset.
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [29:0] m0_adr, m1_adr;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r;
    logic        m0_ack, m1_ack;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [29:0] s_adr;
    logic [3:0]  s_sel;
    logic [31:0] s_dat_w, s_dat_r;
    logic        grant, busy, timeout;

    int evaluated = 0;
    int failures  = 0;

    always #5 clk = ~clk;

    wb_arbiter2 dut (
        .clk(clk), .rst(rst),
        .m0__cyc(m0_cyc), .m0__stb(m0_stb), .m0__we(m0_we), .m0__adr(m0_adr),
        .m0__sel(m0_sel), .m0__dat_w(m0_dat_w), .m0__dat_r(m0_dat_r), .m0__ack(m0_ack),
        .m1__cyc(m1_cyc), .m1__stb(m1_stb), .m1__we(m1_we), .m1__adr(m1_adr),
        .m1__sel(m1_sel), .m1__dat_w(m1_dat_w), .m1__dat_r(m1_dat_r), .m1__ack(m1_ack),
        .s__cyc(s_cyc), .s__stb(s_stb), .s__we(s_we), .s__adr(s_adr),
        .s__sel(s_sel), .s__dat_w(s_dat_w), .s__dat_r(s_dat_r), .s__ack(s_ack),
        .grant(grant), .busy(busy), .timeout(timeout)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        evaluated++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                                 input logic [29:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        if (m == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_sel = sel; m0_dat_w = dat;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_sel = sel; m1_dat_w = dat;
        end
    endtask

    task automatic driveSlave(input logic ack, input logic [31:0] dat);
        s_ack = ack;
        s_dat_r = dat;
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, '0, '0, '0);
        applyStimulus(1, 0, 0, 0, '0, '0, '0);
        driveSlave(0, '0);
        #2;
        checkOutput("rst_s_cyc", 32'(s_cyc), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_grant", 32'(grant), 0);
        checkOutput("rst_timeout", 32'(timeout), 0);
        checkOutput("rst_m0_ack", 32'(m0_ack), 0);
        tick();
        tick();
        rst = 1'b0;

        $display("[TB] m0 single read");
        applyStimulus(0, 1, 1, 0, 30'h100, 4'hF, 32'h0);
        #1;
        checkOutput("t1_latency_s_cyc", 32'(s_cyc), 0);
        tick();
        checkOutput("t1_s_cyc", 32'(s_cyc), 1);
        checkOutput("t1_s_adr", 32'(s_adr), 32'h100);
        checkOutput("t1_grant", 32'(grant), 0);
        checkOutput("t1_busy", 32'(busy), 1);
        checkOutput("t1_m0_ack_early", 32'(m0_ack), 0);
        tick();
        checkOutput("t1_m0_ack_wait", 32'(m0_ack), 0);
        tick();
        driveSlave(1, 32'hDEADBEEF);
        #1;
        checkOutput("t1_m0_ack", 32'(m0_ack), 1);
        checkOutput("t1_m0_dat_r", m0_dat_r, 32'hDEADBEEF);
        checkOutput("t1_m1_ack", 32'(m1_ack), 0);
        tick();
        driveSlave(0, '0);
        applyStimulus(0, 0, 0, 0, 30'h100, 4'hF, 32'h0);
        #1;
        checkOutput("t1_m0_ack_pulse", 32'(m0_ack), 0);
        checkOutput("t1_s_cyc_drop", 32'(s_cyc), 0);
        tick();
        checkOutput("t1_idle_busy", 32'(busy), 0);

        $display("[TB] simultaneous requests after reset");
        doReset();
        applyStimulus(0, 1, 1, 0, 30'h200, 4'hF, 32'h0);
        applyStimulus(1, 1, 1, 1, 30'h300, 4'h3, 32'h12345678);
        tick();
        checkOutput("t2_grant0", 32'(grant), 0);
        checkOutput("t2_s_adr0", 32'(s_adr), 32'h200);
        driveSlave(1, 32'h11);
        #1;
        checkOutput("t2_m0_ack", 32'(m0_ack), 1);
        checkOutput("t2_m1_ack", 32'(m1_ack), 0);
        checkOutput("t2_m1_dat_r", m1_dat_r, 0);
        tick();
        driveSlave(0, '0);
        applyStimulus(0, 0, 0, 0, '0, '0, '0);
        #1;
        checkOutput("t2_s_cyc_drop", 32'(s_cyc), 0);
        tick();
        checkOutput("t2_gap_busy", 32'(busy), 0);
        checkOutput("t2_gap_s_cyc", 32'(s_cyc), 0);
        tick();
        checkOutput("t2_grant1", 32'(grant), 1);
        checkOutput("t2_s_cyc1", 32'(s_cyc), 1);
        checkOutput("t2_s_adr1", 32'(s_adr), 32'h300);
        checkOutput("t2_s_we1", 32'(s_we), 1);
        checkOutput("t2_s_sel1", 32'(s_sel), 32'h3);
        checkOutput("t2_s_dat_w1", s_dat_w, 32'h12345678);
        driveSlave(1, 32'h22);
        #1;
        checkOutput("t2_m1_ack1", 32'(m1_ack), 1);
        checkOutput("t2_m0_ack1", 32'(m0_ack), 0);
        tick();
        driveSlave(0, '0);
        applyStimulus(1, 0, 0, 0, '0, '0, '0);
        tick();

        $display("[TB] alternating grants");
        applyStimulus(0, 1, 1, 0, 30'h10, 4'hF, 32'h0);
        applyStimulus(1, 1, 1, 0, 30'h20, 4'hF, 32'h0);
        tick();
        checkOutput("t3_grant_a", 32'(grant), 0);
        driveSlave(1, 32'h1);
        tick();
        driveSlave(0, '0);
        applyStimulus(0, 0, 0, 0, '0, '0, '0);
        tick();
        applyStimulus(0, 1, 1, 0, 30'h14, 4'hF, 32'h0);
        tick();
        checkOutput("t3_grant_b", 32'(grant), 1);
        checkOutput("t3_s_adr_b", 32'(s_adr), 32'h20);
        driveSlave(1, 32'h2);
        tick();
        driveSlave(0, '0);
        applyStimulus(1, 0, 0, 0, '0, '0, '0);
        tick();
        applyStimulus(1, 1, 1, 0, 30'h24, 4'hF, 32'h0);
        tick();
        checkOutput("t3_grant_c", 32'(grant), 0);
        checkOutput("t3_s_adr_c", 32'(s_adr), 32'h14);
        driveSlave(1, 32'h3);
        tick();
        driveSlave(0, '0);
        applyStimulus(0, 0, 0, 0, '0, '0, '0);
        applyStimulus(1, 0, 0, 0, '0, '0, '0);
        tick();

        $display("[TB] watchdog abort on m1");
        applyStimulus(1, 1, 1, 0, 30'h40, 4'hF, 32'h0);
        tick();
        checkOutput("t4_s_stb", 32'(s_stb), 1);
        for (int i = 1; i <= 7; i++) begin
            tick();
            checkOutput($sformatf("t4_wait%0d_timeout", i), 32'(timeout), 0);
        end
        checkOutput("t4_wait_s_cyc", 32'(s_cyc), 1);
        tick();
        checkOutput("t4_abort_timeout", 32'(timeout), 1);
        checkOutput("t4_abort_m1_ack", 32'(m1_ack), 1);
        checkOutput("t4_abort_m1_dat_r", m1_dat_r, 32'hFFFFFFFF);
        checkOutput("t4_abort_s_cyc", 32'(s_cyc), 0);
        checkOutput("t4_abort_m0_ack", 32'(m0_ack), 0);
        checkOutput("t4_abort_busy", 32'(busy), 1);
        applyStimulus(1, 0, 0, 0, '0, '0, '0);
        tick();
        checkOutput("t4_after_timeout", 32'(timeout), 0);
        checkOutput("t4_after_m1_ack", 32'(m1_ack), 0);
        checkOutput("t4_after_busy", 32'(busy), 0);

        $display("[TB] ack on the timeout cycle");
        applyStimulus(0, 1, 1, 0, 30'h80, 4'hF, 32'h0);
        tick();
        for (int i = 1; i <= 7; i++) tick();
        driveSlave(1, 32'hCAFEF00D);
        #1;
        checkOutput("t5_m0_ack", 32'(m0_ack), 1);
        checkOutput("t5_m0_dat_r", m0_dat_r, 32'hCAFEF00D);
        checkOutput("t5_timeout_edge", 32'(timeout), 0);
        tick();
        driveSlave(0, '0);
        #1;
        checkOutput("t5_no_abort_timeout", 32'(timeout), 0);
        checkOutput("t5_no_abort_s_cyc", 32'(s_cyc), 1);
        checkOutput("t5_no_abort_m0_ack", 32'(m0_ack), 0);
        applyStimulus(0, 0, 0, 0, '0, '0, '0);
        tick();
        driveSlave(1, 32'h55);
        #1;
        checkOutput("t5_stale_m0_ack", 32'(m0_ack), 0);
        checkOutput("t5_stale_m1_ack", 32'(m1_ack), 0);
        driveSlave(0, '0);

        $display("[TB] reset mid-busy");
        applyStimulus(1, 1, 1, 0, 30'h99, 4'hF, 32'h0);
        tick();
        checkOutput("t6_pre_s_cyc", 32'(s_cyc), 1);
        driveSlave(1, 32'h77);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_s_cyc", 32'(s_cyc), 0);
        checkOutput("t6_rst_busy", 32'(busy), 0);
        checkOutput("t6_rst_m1_ack", 32'(m1_ack), 0);
        driveSlave(0, '0);
        tick();
        rst = 1'b0;
        applyStimulus(0, 1, 1, 0, 30'hAA, 4'hF, 32'h0);
        tick();
        checkOutput("t6_post_grant", 32'(grant), 0);
        checkOutput("t6_post_s_adr", 32'(s_adr), 32'hAA);
        applyStimulus(0, 0, 0, 0, '0, '0, '0);
        applyStimulus(1, 0, 0, 0, '0, '0, '0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end

endmodule
